// File: rtl/panel_frame_loader.sv
// panel_frame_loader
//   Write side of a double-buffered panel frame store. Bytes arrive as
//   R,G,B triplets over a valid/ready stream. Each assembled pixel is written
//   into the back bank (~disp_bank). When the last pixel of a frame has been
//   written, the loader stalls the stream until the next display vsync. It
//   then swaps banks, so the panel never shows a partially loaded frame.
//
// Parameters
//   AW    pixel address width per bank
//   NPIX  pixels per frame (must be <= 2**AW)
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   s_data      stream byte
//   s_valid     s_data valid
//   s_sof       byte is R of pixel 0 of a new frame
//   s_ready     loader accepts a byte this cycle (decoded from state)
//   vsync       one-cycle display frame-boundary strobe
//   mem_we      one-cycle write strobe to the frame store
//   mem_addr    {bank, pixel_index}
//   mem_wdata   {R,G,B}, R in [23:16]
//   disp_bank   bank currently shown by the display
//   frame_done  one-cycle pulse on a bank swap
//   err_short   one-cycle pulse when a frame is aborted by an early s_sof
module panel_frame_loader #(
  parameter int AW   = 12,
  parameter int NPIX = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  input  logic          s_sof,
  output logic          s_ready,
  input  logic          vsync,
  output logic          mem_we,
  output logic [AW:0]   mem_addr,
  output logic [23:0]   mem_wdata,
  output logic          disp_bank,
  output logic          frame_done,
  output logic          err_short
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] pix_cnt;
  logic [7:0]    r_byte;
  logic [7:0]    g_byte;

  // Ready is a pure decode of the state register.
  always_comb begin
    s_ready = 1'b0;
    case (state)
      IDLE:      s_ready = 1'b1;
      LOAD:      s_ready = 1'b1;
      WAIT_SWAP: s_ready = 1'b0;
      default:   s_ready = 1'b0;
    endcase
  end

  // Loader FSM: byte assembly, pixel writes, bank swap and pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      pix_cnt    <= '0;
      r_byte     <= 8'd0;
      g_byte     <= 8'd0;
      disp_bank  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 24'd0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      // Pulse outputs default low; mem_addr/mem_wdata simply hold.
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      case (state)
        IDLE: begin
          // Bytes before the first s_sof are dropped.
          if (s_valid && s_sof) begin
            r_byte   <= s_data;
            byte_cnt <= 2'd1;
            pix_cnt  <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (s_valid) begin
            if (s_sof) begin
              // Early start of frame at any byte position restarts the frame;
              // pixels already in the back bank are simply overwritten.
              err_short <= 1'b1;
              r_byte    <= s_data;
              byte_cnt  <= 2'd1;
              pix_cnt   <= '0;
            end else begin
              case (byte_cnt)
                2'd0: begin
                  r_byte   <= s_data;
                  byte_cnt <= 2'd1;
                end
                2'd1: begin
                  g_byte   <= s_data;
                  byte_cnt <= 2'd2;
                end
                2'd2: begin
                  mem_we    <= 1'b1;
                  mem_addr  <= {~disp_bank, pix_cnt};
                  mem_wdata <= {r_byte, g_byte, s_data};
                  byte_cnt  <= 2'd0;
                  if (pix_cnt == LAST_PIX) begin
                    pix_cnt <= '0;
                    state   <= WAIT_SWAP;
                  end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                  end
                end
                default: byte_cnt <= 2'd0;
              endcase
            end
          end
        end
        WAIT_SWAP: begin
          // A vsync coinciding with the last B byte was sampled in LOAD and
          // is ignored; only a later vsync reaches here.
          if (vsync) begin
            disp_bank  <= ~disp_bank;
            frame_done <= 1'b1;
            byte_cnt   <= 2'd0;
            pix_cnt    <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_frame_loader.sv
module tb_panel_frame_loader;

  localparam int AW   = 12;
  localparam int NPIX = 4096;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_sof;
  logic        s_ready;
  logic        vsync;
  logic        mem_we;
  logic [AW:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        disp_bank;
  logic        frame_done;
  logic        err_short;

  panel_frame_loader #(.AW(AW), .NPIX(NPIX)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_sof(s_sof), .s_ready(s_ready), .vsync(vsync), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .disp_bank(disp_bank),
    .frame_done(frame_done), .err_short(err_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks byte position within the current frame and
  // predicts the outputs visible after each rising edge.
  typedef struct {
    logic        bank;
    logic        full;
    logic        active;
    int          pos;
    logic [7:0]  rb;
    logic [7:0]  gb;
    logic        we;
    logic        fd;
    logic        err;
    logic        ad_chk;
    logic [12:0] addr;
    logic [23:0] data;
  } model_t;

  model_t m;

  function automatic model_t step(model_t c, logic rst, logic v, logic sof,
                                  logic [7:0] d, logic vs);
    model_t n;
    n = c;
    n.we = 1'b0; n.fd = 1'b0; n.err = 1'b0; n.ad_chk = 1'b0;
    if (!rst) begin
      n.bank = 1'b0; n.full = 1'b0; n.active = 1'b0; n.pos = 0;
      n.ad_chk = 1'b1; n.addr = 13'd0; n.data = 24'd0;
    end else if (c.full) begin
      if (vs) begin
        n.bank = ~c.bank; n.fd = 1'b1; n.full = 1'b0; n.active = 1'b0;
      end
    end else if (v) begin
      if (sof) begin
        n.err = c.active; n.active = 1'b1; n.pos = 0;
      end
      if (n.active) begin
        case (n.pos % 3)
          0: n.rb = d;
          1: n.gb = d;
          default: begin
            n.we = 1'b1; n.ad_chk = 1'b1;
            n.addr = {~c.bank, 12'(n.pos / 3)};
            n.data = {n.rb, n.gb, d};
            if (n.pos / 3 == NPIX - 1) n.full = 1'b1;
          end
        endcase
        n.pos = n.pos + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= step(m, rst_n, s_valid, s_sof, s_data, vsync);

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int fd_cnt = 0;
  logic [12:0] wa_q[$];
  logic [23:0] wd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model plus write/pulse logging.
  task automatic cycle_check();
    chk("s_ready", {31'd0, s_ready}, {31'd0, ~m.full});
    chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m.fd});
    chk("err_short", {31'd0, err_short}, {31'd0, m.err});
    chk("disp_bank", {31'd0, disp_bank}, {31'd0, m.bank});
    if (m.ad_chk) begin
      chk("mem_addr", {19'd0, mem_addr}, {19'd0, m.addr});
      chk("mem_wdata", {8'd0, mem_wdata}, {8'd0, m.data});
    end
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    if (err_short === 1'b1) err_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic send(input logic [7:0] d, input logic sof, input logic vs);
    @(negedge clk);
    cycle_check();
    s_data = d; s_valid = 1'b1; s_sof = sof; vsync = vs;
  endtask

  task automatic idle(input logic vs);
    @(negedge clk);
    cycle_check();
    s_data = 8'd0; s_valid = 1'b0; s_sof = 1'b0; vsync = vs;
  endtask

  function automatic logic [7:0] pix_byte(int i, int b);
    logic [11:0] x;
    logic [23:0] p;
    x = i[11:0];
    p = {x[7:0], 8'hA5, x[11:4]};
    if (b == 0) return p[23:16];
    else if (b == 1) return p[15:8];
    else return p[7:0];
  endfunction

  int base;
  int ebase;
  int fbase;

  initial begin
    rst_n = 1'b0; s_data = 8'd0; s_valid = 1'b0; s_sof = 1'b0; vsync = 1'b0;
    idle(1'b0); idle(1'b0); idle(1'b0);
    chk("reset_addr", {19'd0, mem_addr}, 32'h0);
    chk("reset_ready", {31'd0, s_ready}, 32'h1);
    chk("reset_bank", {31'd0, disp_bank}, 32'h0);
    rst_n = 1'b1;

    // Full frame into bank 1.
    base = wa_q.size(); ebase = err_cnt;
    for (int i = 0; i < NPIX; i++)
      for (int b = 0; b < 3; b++)
        send(pix_byte(i, b), (i == 0 && b == 0), 1'b0);
    idle(1'b0); idle(1'b0);
    chk("f1_count", wa_q.size() - base, 32'd4096);
    chk("f1_first_addr", {19'd0, wa_q[base]}, 32'h1000);
    chk("f1_first_data", {8'd0, wd_q[base]}, 32'h00A500);
    chk("f1_last_addr", {19'd0, wa_q[wa_q.size()-1]}, 32'h1FFF);
    chk("f1_last_data", {8'd0, wd_q[wd_q.size()-1]}, 32'hFFA5FF);
    chk("f1_ready_low", {31'd0, s_ready}, 32'h0);
    chk("f1_bank_held", {31'd0, disp_bank}, 32'h0);
    chk("f1_no_err", err_cnt - ebase, 32'd0);

    // Swap on vsync after a hold.
    repeat (18) idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("swap_fd", {31'd0, frame_done}, 32'h1);
    chk("swap_bank", {31'd0, disp_bank}, 32'h1);
    chk("swap_ready", {31'd0, s_ready}, 32'h1);
    idle(1'b0);
    chk("swap_fd_1cyc", {31'd0, frame_done}, 32'h0);

    // Garbage before sof, then a frame with gaps and stray vsyncs.
    base = wa_q.size(); fbase = fd_cnt;
    for (int k = 0; k < 7; k++) send(8'hE0 + 8'(k), 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    chk("garbage_no_we", wa_q.size() - base, 32'd0);
    for (int i = 0; i < NPIX; i++)
      for (int b = 0; b < 3; b++) begin
        while ($urandom_range(0, 3) == 0) idle(1'b0);
        send(pix_byte(i, b), (i == 0 && b == 0),
             ((i == 100 && b == 1) || (i == NPIX - 1 && b == 2)));
      end
    idle(1'b0); idle(1'b0);
    chk("f2_count", wa_q.size() - base, 32'd4096);
    chk("f2_first_addr", {19'd0, wa_q[base]}, 32'h0000);
    chk("f2_last_addr", {19'd0, wa_q[wa_q.size()-1]}, 32'h0FFF);
    chk("f2_last_data", {8'd0, wd_q[wd_q.size()-1]}, 32'hFFA5FF);
    repeat (4) idle(1'b0);
    chk("f2_no_swap", fd_cnt - fbase, 32'd0);
    chk("f2_bank_held", {31'd0, disp_bank}, 32'h1);
    idle(1'b1); idle(1'b0);
    chk("f2_swap_bank", {31'd0, disp_bank}, 32'h0);
    chk("f2_swap_fd", fd_cnt - fbase, 32'd1);

    // Reset in the middle of a frame (at pixel 2000).
    for (int i = 0; i <= 2000; i++)
      for (int b = 0; b < 3; b++)
        if (i < 2000 || b == 0) send(pix_byte(i, b), (i == 0 && b == 0), 1'b0);
    idle(1'b0);
    rst_n = 1'b0;
    idle(1'b0); idle(1'b0);
    chk("rst_we", {31'd0, mem_we}, 32'h0);
    chk("rst_addr", {19'd0, mem_addr}, 32'h0);
    chk("rst_data", {8'd0, mem_wdata}, 32'h0);
    chk("rst_bank", {31'd0, disp_bank}, 32'h0);
    chk("rst_ready", {31'd0, s_ready}, 32'h1);
    rst_n = 1'b1;

    // Restart after reset, then an early sof on the R byte of pixel 10.
    base = wa_q.size(); ebase = err_cnt;
    for (int i = 0; i <= 10; i++)
      for (int b = 0; b < 3; b++)
        if (i < 10 || b == 0) send(pix_byte(i, b), (i == 0 && b == 0), 1'b0);
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    chk("early_err_pulse", {31'd0, err_short}, 32'h1);
    send(8'h33, 1'b0, 1'b0);
    chk("early_err_1cyc", {31'd0, err_short}, 32'h0);
    idle(1'b0); idle(1'b0);
    chk("restart_first_addr", {19'd0, wa_q[base]}, 32'h1000);
    chk("early_count", wa_q.size() - base, 32'd11);
    chk("early_addr", {19'd0, wa_q[wa_q.size()-1]}, 32'h1000);
    chk("early_data", {8'd0, wd_q[wd_q.size()-1]}, 32'h112233);
    chk("early_err_cnt", err_cnt - ebase, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
